// File: rtl/md_seq_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StWrite = 2'd2,
        StExcp  = 2'd3
    } md_state_e;

    // Reason an operation ends in the exception state
    typedef enum logic {
        CauseDiv0    = 1'b0,
        CauseTimeout = 1'b1
    } excp_cause_e;

    // Operation select encodings as presented on op_div
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Saturating increment for the 16-bit performance counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Clearable, saturating RUN-cycle counter with a terminal-count flag at MAX_CYCLES-1.
module md_timeout_counter #(
    parameter int unsigned MAX_CYCLES = 34,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_q;

    // Count enabled cycles; clear has priority and the count sticks at all-ones
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal = (count_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: starts the unit, waits for done, commits HI/LO or
// raises a divide-by-zero / timeout exception, and stalls mfhi/mflo while busy.
// Optional build macro MD_PERF_CNT_EN adds perf_ops / perf_stall counters.
module md_sequencer
    import md_seq_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 34,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic        done,
    input  logic        div_by0,
    input  logic        hilo_read_req,
    output logic        hd_control,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        stall,
    output logic        op_done,
    output logic        excp_div0,
    output logic        excp_timeout
`ifdef MD_PERF_CNT_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    md_state_e   state_q;
    logic        op_q;
    logic        terminal;
    logic        div0_hit;
    logic        run_excp;
    excp_cause_e run_cause;

    md_timeout_counter #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timeout_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == StIdle),
        .enable   (state_q == StRun),
        .terminal (terminal)
    );

    // Decide the RUN exit: div0 beats done, done beats the timeout
    always_comb begin
        div0_hit  = (op_q == OP_DIV) && div_by0;
        run_excp  = div0_hit || (!done && terminal);
        run_cause = div0_hit ? CauseDiv0 : CauseTimeout;
    end

    // Sequencer FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OP_MULT;
            hd_control   <= 1'b0;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            busy         <= 1'b0;
            op_done      <= 1'b0;
            excp_div0    <= 1'b0;
            excp_timeout <= 1'b0;
        end else begin
            hd_control   <= 1'b0;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            op_done      <= 1'b0;
            excp_div0    <= 1'b0;
            excp_timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q       <= op_div;
                        state_q    <= StRun;
                        hd_control <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StRun: begin
                    if (run_excp) begin
                        state_q      <= StExcp;
                        excp_div0    <= (run_cause == CauseDiv0);
                        excp_timeout <= (run_cause == CauseTimeout);
                    end else if (done) begin
                        state_q  <= StWrite;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        op_done  <= 1'b1;
                    end
                end
                StWrite, StExcp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign stall = hilo_read_req & busy;

`ifdef MD_PERF_CNT_EN
    // Saturating counts of commits and stalled cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops   <= 16'd0;
            perf_stall <= 16'd0;
        end else begin
            if (op_done) begin
                perf_ops <= sat_inc16(perf_ops);
            end
            if (stall) begin
                perf_stall <= sat_inc16(perf_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: a cycle-indexed transaction model is
// compared against every output each cycle, plus literal per-operation totals.
module tb_md_sequencer;

    localparam int MAX = 34;

    logic clock = 1'b0;
    logic reset, start, op_div, done, div_by0, hilo_read_req;
    logic hd_control, hi_write, lo_write, busy, stall, op_done, excp_div0, excp_timeout;
`ifdef MD_PERF_CNT_EN
    logic [15:0] perf_ops, perf_stall;
`endif

    md_sequencer #(
        .MAX_CYCLES (MAX),
        .CNT_W      (6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .op_div        (op_div),
        .done          (done),
        .div_by0       (div_by0),
        .hilo_read_req (hilo_read_req),
        .hd_control    (hd_control),
        .hi_write      (hi_write),
        .lo_write      (lo_write),
        .busy          (busy),
        .stall         (stall),
        .op_done       (op_done),
        .excp_div0     (excp_div0),
        .excp_timeout  (excp_timeout)
`ifdef MD_PERF_CNT_EN
        ,
        .perf_ops      (perf_ops),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Transaction model: an accepted op occupies edges acc..end; end is the edge
    // where the op resolves, and the cycle after end is the commit/exception cycle.
    bit m_active   = 1'b0;
    bit m_resolved = 1'b0;
    bit m_op       = 1'b0;
    int m_acc      = 0;
    int m_end      = 0;
    int m_kind     = 0;  // 0 commit, 1 div0, 2 timeout
    int m_ops      = 0;
    int m_stalls   = 0;

    // Measured per-operation totals
    int n_busy, n_hd, n_hi, n_lo, n_opd, n_d0, n_to, n_stall;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_pulse(input int kind, input int t);
        return m_active && m_resolved && (t == m_end) && (m_kind == kind);
    endfunction

    // Model update at each rising edge, using the inputs the DUT samples
    always @(posedge clock) begin
        int prev;
        prev = cyc;
        cyc  = cyc + 1;
        if (reset) begin
            m_active = 1'b0;
            m_ops    = 0;
            m_stalls = 0;
        end else begin
            if (exp_pulse(0, prev) && m_ops < 65535) m_ops++;
            if (hilo_read_req && m_active && m_stalls < 65535) m_stalls++;
            if (!m_active) begin
                if (start) begin
                    m_active   = 1'b1;
                    m_resolved = 1'b0;
                    m_acc      = cyc;
                    m_op       = op_div;
                end
            end else if (!m_resolved) begin
                if (m_op && div_by0) begin
                    m_resolved = 1'b1; m_kind = 1; m_end = cyc;
                end else if (done) begin
                    m_resolved = 1'b1; m_kind = 0; m_end = cyc;
                end else if (cyc - m_acc == MAX) begin
                    m_resolved = 1'b1; m_kind = 2; m_end = cyc;
                end
            end else if (cyc == m_end + 1) begin
                m_active = 1'b0;
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clock) begin
        if (cyc >= 1) begin
            check("busy", {15'd0, busy}, {15'd0, m_active});
            check("hd_control", {15'd0, hd_control},
                  {15'd0, m_active && !m_resolved && (cyc == m_acc)});
            check("hi_write", {15'd0, hi_write}, {15'd0, exp_pulse(0, cyc)});
            check("lo_write", {15'd0, lo_write}, {15'd0, exp_pulse(0, cyc)});
            check("op_done", {15'd0, op_done}, {15'd0, exp_pulse(0, cyc)});
            check("excp_div0", {15'd0, excp_div0}, {15'd0, exp_pulse(1, cyc)});
            check("excp_timeout", {15'd0, excp_timeout}, {15'd0, exp_pulse(2, cyc)});
            check("stall", {15'd0, stall}, {15'd0, hilo_read_req && m_active});
`ifdef MD_PERF_CNT_EN
            check("perf_ops", perf_ops, 16'(m_ops));
            check("perf_stall", perf_stall, 16'(m_stalls));
`endif
            n_busy  += int'(busy);
            n_hd    += int'(hd_control);
            n_hi    += int'(hi_write);
            n_lo    += int'(lo_write);
            n_opd   += int'(op_done);
            n_d0    += int'(excp_div0);
            n_to    += int'(excp_timeout);
            n_stall += int'(stall);
        end
    end

    task automatic clear_totals();
        n_busy = 0; n_hd = 0; n_hi = 0; n_lo = 0;
        n_opd = 0; n_d0 = 0; n_to = 0; n_stall = 0;
    endtask

    // Issue one op; RUN-cycle indices (1-based) select when each input pulses, 0 = never
    task automatic run_op(input logic op, input int done_at, input int div0_at,
                          input int restart_at, input int reset_at, input logic hilo);
        clear_totals();
        hilo_read_req = hilo;
        op_div        = op;
        start         = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int j = 1; j <= MAX + 4; j++) begin
            done    = (j == done_at);
            div_by0 = (j == div0_at);
            start   = (j == restart_at);
            reset   = (j == reset_at);
            @(posedge clock); #1;
        end
        done = 1'b0; div_by0 = 1'b0; start = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        hilo_read_req = 1'b0;
    endtask

    task automatic expect_totals(input string tag, input int busy_c, input int hd_c,
                                 input int wr_c, input int d0_c, input int to_c);
        check({tag, "_busy_cycles"}, 16'(n_busy), 16'(busy_c));
        check({tag, "_hd_pulses"}, 16'(n_hd), 16'(hd_c));
        check({tag, "_hi_writes"}, 16'(n_hi), 16'(wr_c));
        check({tag, "_lo_writes"}, 16'(n_lo), 16'(wr_c));
        check({tag, "_op_done"}, 16'(n_opd), 16'(wr_c));
        check({tag, "_div0"}, 16'(n_d0), 16'(d0_c));
        check({tag, "_timeout"}, 16'(n_to), 16'(to_c));
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; op_div = 1'b1; done = 1'b1;
        div_by0 = 1'b1; hilo_read_req = 1'b1;
        clear_totals();
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs",
              {8'd0, hd_control, hi_write, lo_write, busy, stall, op_done, excp_div0, excp_timeout},
              16'd0);
        reset = 1'b0; start = 1'b0; op_div = 1'b0; done = 1'b0;
        div_by0 = 1'b0; hilo_read_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // mult, done in the 32nd RUN cycle
        run_op(1'b0, 32, 0, 0, 0, 1'b0);
        expect_totals("mult32", 33, 1, 1, 0, 0);
        // div, divide-by-zero in the 3rd RUN cycle
        run_op(1'b1, 0, 3, 0, 0, 1'b0);
        expect_totals("div0_at3", 4, 1, 0, 1, 0);
        // div, done and div_by0 together: exception wins
        run_op(1'b1, 5, 5, 0, 0, 1'b0);
        expect_totals("div0_and_done", 6, 1, 0, 1, 0);
        // mult ignores div_by0
        run_op(1'b0, 4, 2, 0, 0, 1'b0);
        expect_totals("mult_ign_div0", 5, 1, 1, 0, 0);
        // done never arrives
        run_op(1'b0, 0, 0, 0, 0, 1'b0);
        expect_totals("timeout", 35, 1, 0, 0, 1);
        // done in the very first RUN cycle
        run_op(1'b1, 1, 0, 0, 0, 1'b0);
        expect_totals("done_first", 2, 1, 1, 0, 0);
        // read held through a mult, second start mid-run ignored
        run_op(1'b0, 32, 0, 5, 0, 1'b1);
        expect_totals("stall_mult", 33, 1, 1, 0, 0);
        check("stall_mult_stall_cycles", 16'(n_stall), 16'd33);
        // start during the WRITE cycle is ignored
        run_op(1'b0, 3, 0, 4, 0, 1'b0);
        expect_totals("start_in_write", 4, 1, 1, 0, 0);
        // reset in the 10th RUN cycle aborts the op
        run_op(1'b1, 0, 0, 0, 10, 1'b0);
        expect_totals("reset_abort", 10, 1, 0, 0, 0);
        // fresh op after the abort completes normally
        run_op(1'b0, 3, 0, 0, 0, 1'b0);
        expect_totals("after_reset", 4, 1, 1, 0, 0);
`ifdef MD_PERF_CNT_EN
        check("perf_ops_after_reset", perf_ops, 16'd1);
        check("perf_stall_after_reset", perf_stall, 16'd0);
`endif

        repeat (2) @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the multiply/divide unit of the multicycle datapath on behalf of the main control FSM.
- Accepts a start request, pulses the unit's start control and waits for its done flag.
- On success, commits HI/LO. On divide-by-zero or timeout, raises an exception request instead.
- Stalls mfhi/mflo reads while an operation is in flight.

Parameters:
- MAX_CYCLES, 34, RUN-state cycle budget before a timeout exception; legal range 2..63.
- CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request from main control; sampled only in IDLE.
- op_div  in  1  operation select, sampled with start: 0 = mult, 1 = div.
- done  in  1  completion flag from mult/div unit.
- div_by0  in  1  divide-by-zero flag from mult/div unit.
- hilo_read_req  in  1  main control wants HI or LO this cycle (mfhi/mflo).
- hd_control  out  1  start pulse to mult/div unit.
- hi_write  out  1  HI register write enable.
- lo_write  out  1  LO register write enable.
- busy  out  1  operation in flight.
- stall  out  1  hold main control; equals hilo_read_req AND busy.
- op_done  out  1  one-cycle pulse on a successful commit.
- excp_div0  out  1  one-cycle exception request, divide by zero.
- excp_timeout  out  1  one-cycle exception request, unit never signalled done.

Behaviour:
- Reset:
  - state = IDLE; counter = 0; latched op = 0.
  - All outputs are 0 in the cycle following reset assertion.
  - A reset asserted mid-operation aborts it; no HI/LO write and no exception are produced.
- States: IDLE, RUN, WRITE, EXCP. All outputs are registered or decoded from state only; there is no combinational path from start.
- IDLE:
  - On start=1: latch op_div, clear counter, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - hd_control=1 only in the first RUN cycle (counter==0). It is low for the rest of RUN.
  - Counter increments every RUN cycle.
  - Transition priority, highest first:
    - latched op is div and div_by0=1 -> EXCP (div0 cause).
    - done=1 -> WRITE.
    - counter == MAX_CYCLES-1 -> EXCP (timeout cause).
    - otherwise stay in RUN.
  - div_by0 is ignored for mult.
  - done and div_by0 in the same cycle on a div -> exception wins; no write.
  - done in the first RUN cycle is legal: WRITE follows.
- WRITE:
  - hi_write=1, lo_write=1, op_done=1 for exactly one cycle.
  - Next state is IDLE.
- EXCP:
  - Exactly one of excp_div0 / excp_timeout is high for one cycle, according to the latched cause.
  - hi_write and lo_write stay 0. Next state is IDLE.
- busy = 1 in RUN, WRITE and EXCP; 0 in IDLE.
  - Minimum occupancy is 2 cycles: one RUN + one WRITE/EXCP.
  - Latency from start to op_done = unit latency + 2 cycles.
- start while busy is ignored; it is not queued. Main control must re-issue the request once busy=0.
- stall:
  - Combinational AND of hilo_read_req and busy.
  - Deasserted in the IDLE cycle after WRITE, so a stalled read sees the committed HI/LO.
- Counter saturates; it never wraps within a RUN.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- Defined:
  - Adds output perf_ops (16 bits): count of successful commits.
  - Adds output perf_stall (16 bits): count of cycles with stall=1.
  - Both counters clear on reset and saturate at 16'hFFFF.
- Undefined: neither port nor either counter exists. Core behaviour is identical.

Decomposition:
- Package md_seq_pkg holds:
  - state typedef: IDLE=2'd0, RUN=2'd1, WRITE=2'd2, EXCP=2'd3.
  - excp-cause typedef: DIV0, TIMEOUT.
  - op encodings: OP_MULT=1'b0, OP_DIV=1'b1.
- One sub-module is natural: md_timeout_counter. It is a clearable, saturating CNT_W-bit counter with a terminal-count output at MAX_CYCLES-1. The FSM stays in the top module.

Test Plan:
- start=1, op_div=0, done after 32 cycles -> hd_control high for 1 cycle; busy for 33 cycles; hi_write/lo_write/op_done pulse once; no exception.
- start=1, op_div=1, div_by0=1 in the 3rd RUN cycle -> excp_div0 pulses once; hi_write stays 0; back in IDLE 2 cycles later.
- start=1, op_div=1, done=1 and div_by0=1 in the same cycle -> excp_div0 only; no write.
- start=1, done never asserted -> excp_timeout pulses in the cycle after the counter hits 33; busy drops the next cycle.
- hilo_read_req held high during a 32-cycle mult -> stall high exactly while busy; low in the first IDLE cycle. A second start during busy is ignored.
- reset pulsed in the 10th RUN cycle -> all outputs 0 the next cycle; no write or exception. A fresh start then completes normally. With MD_PERF_CNT_EN: perf_ops = 1 after that op.
